// File: rtl/scie_pipelined.sv
// Complex FIR custom-instruction unit: coefficient/sample registers, a registered
// per-tap product stage and a registered tap-sum read result.
module scie_pipelined #(
  parameter int unsigned NTAPS = 5,
  parameter int unsigned W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_valid,
  input  logic [31:0]         io_insn,
  input  logic signed [W-1:0] io_rs1_real,
  input  logic signed [W-1:0] io_rs1_imag,
  input  logic [31:0]         io_rs2,
  output logic signed [W-1:0] io_rd_real,
  output logic signed [W-1:0] io_rd_imag
);

  localparam int unsigned PW = 2 * W + 1;
  localparam int unsigned SW = PW + $clog2(NTAPS + 1);

  localparam logic [6:0] OpCoef = 7'h0B;
  localparam logic [6:0] OpPush = 7'h2B;
  localparam logic [6:0] OpRead = 7'h5B;

  logic signed [W-1:0]  coef_r_q [NTAPS];
  logic signed [W-1:0]  coef_i_q [NTAPS];
  logic signed [W-1:0]  x_r_q    [NTAPS];
  logic signed [W-1:0]  x_i_q    [NTAPS];
  logic signed [PW-1:0] p_r_q    [NTAPS];
  logic signed [PW-1:0] p_i_q    [NTAPS];
  logic signed [PW-1:0] p_r_d    [NTAPS];
  logic signed [PW-1:0] p_i_d    [NTAPS];
  logic signed [W-1:0]  rd_r_q, rd_i_q;
  logic signed [SW-1:0] sum_r, sum_i;

  logic [6:0] opcode;
  logic [2:0] coef_idx;
  logic       do_coef, do_push, do_read;

  assign opcode   = io_insn[6:0];
  assign coef_idx = io_rs2[2:0];
  assign do_coef  = io_valid && (opcode == OpCoef);
  assign do_push  = io_valid && (opcode == OpPush);
  assign do_read  = io_valid && (opcode == OpRead);

  always_comb begin
    sum_r = '0;
    sum_i = '0;
    for (int k = 0; k < NTAPS; k++) begin
      p_r_d[k] = PW'(coef_r_q[k]) * PW'(x_r_q[k]) - PW'(coef_i_q[k]) * PW'(x_i_q[k]);
      p_i_d[k] = PW'(coef_r_q[k]) * PW'(x_i_q[k]) + PW'(coef_i_q[k]) * PW'(x_r_q[k]);
      sum_r    = sum_r + SW'(p_r_q[k]);
      sum_i    = sum_i + SW'(p_i_q[k]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef_r_q[k] <= '0;
        coef_i_q[k] <= '0;
        x_r_q[k]    <= '0;
        x_i_q[k]    <= '0;
        p_r_q[k]    <= '0;
        p_i_q[k]    <= '0;
      end
      rd_r_q <= '0;
      rd_i_q <= '0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        p_r_q[k] <= p_r_d[k];
        p_i_q[k] <= p_i_d[k];
        // Indices >= NTAPS match no tap and are silently dropped.
        if (do_coef && (32'(coef_idx) == k)) begin
          coef_r_q[k] <= io_rs1_real;
          coef_i_q[k] <= io_rs1_imag;
        end
        if (do_push) begin
          if (k == 0) begin
            x_r_q[k] <= io_rs1_real;
            x_i_q[k] <= io_rs1_imag;
          end else begin
            x_r_q[k] <= x_r_q[k-1];
            x_i_q[k] <= x_i_q[k-1];
          end
        end
      end
      if (do_read) begin
        rd_r_q <= sum_r[W-1:0];
        rd_i_q <= sum_i[W-1:0];
      end
    end
  end

  // Result wraps to W bits; upper sum bits are intentionally discarded.
  logic unused_sum_hi;
  assign unused_sum_hi = ^{sum_r[SW-1:W], sum_i[SW-1:W], io_insn[31:7], io_rs2[31:3]};

  assign io_rd_real = rd_r_q;
  assign io_rd_imag = rd_i_q;

endmodule

// File: tb/tb_scie_pipelined.sv
// Directed bench for scie_pipelined: hand-computed complex FIR results after
// coefficient writes, sample pushes, reset and ignored instructions.
module tb_scie_pipelined;

  localparam int unsigned NTAPS = 5;
  localparam int unsigned W     = 16;

  localparam logic [6:0] OpCoef = 7'h0B;
  localparam logic [6:0] OpPush = 7'h2B;
  localparam logic [6:0] OpRead = 7'h5B;
  localparam logic [6:0] OpBad  = 7'h7B;

  logic                clock = 1'b0;
  logic                reset;
  logic                io_valid;
  logic [31:0]         io_insn;
  logic signed [W-1:0] io_rs1_real;
  logic signed [W-1:0] io_rs1_imag;
  logic [31:0]         io_rs2;
  logic signed [W-1:0] io_rd_real;
  logic signed [W-1:0] io_rd_imag;

  int n_checks = 0;
  int n_pass   = 0;

  scie_pipelined #(
    .NTAPS(NTAPS),
    .W    (W)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .io_valid   (io_valid),
    .io_insn    (io_insn),
    .io_rs1_real(io_rs1_real),
    .io_rs1_imag(io_rs1_imag),
    .io_rs2     (io_rs2),
    .io_rd_real (io_rd_real),
    .io_rd_imag (io_rd_imag)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got_r, input int got_i,
                          input int exp_r, input int exp_i);
    n_checks++;
    if (got_r == exp_r && got_i == exp_i) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", tag, got_r, got_i, exp_r, exp_i);
    end
  endtask

  // Drive one instruction at the falling edge; it executes at the next rising edge.
  task automatic step(input logic v, input logic [6:0] op, input int r, input int i,
                      input int idx);
    @(negedge clock);
    io_valid    = v;
    io_insn     = {25'h0, op};
    io_rs1_real = W'(r);
    io_rs1_imag = W'(i);
    io_rs2      = 32'(idx);
  endtask

  task automatic idle();
    step(1'b0, 7'h00, 0, 0, 0);
  endtask

  task automatic read_check(input string tag, input int er, input int ei);
    step(1'b1, OpRead, 0, 0, 0);
    idle();
    check_eq(tag, int'(io_rd_real), int'(io_rd_imag), er, ei);
  endtask

  task automatic push_read(input string tag, input int r, input int i, input int er,
                           input int ei);
    step(1'b1, OpPush, r, i, 0);
    idle();
    read_check(tag, er, ei);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    // A live instruction during reset must not survive it.
    io_valid    = 1'b1;
    io_insn     = {25'h0, OpPush};
    io_rs1_real = W'(77);
    io_rs1_imag = W'(-9);
    io_rs2      = 32'd0;
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b0;
    io_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    io_valid    = 1'b0;
    io_insn     = '0;
    io_rs1_real = '0;
    io_rs1_imag = '0;
    io_rs2      = '0;

    reset_dut();
    check_eq("reset", int'(io_rd_real), int'(io_rd_imag), 0, 0);
    read_check("rst_read", 0, 0);

    step(1'b1, OpCoef, -46, 5, 0);
    step(1'b1, OpCoef, 14, 17, 1);
    step(1'b1, OpCoef, -38, 25, 2);
    step(1'b1, OpCoef, -2, -27, 3);
    step(1'b1, OpCoef, 44, 1, 4);
    push_read("push0", 12, 0, -552, 60);
    push_read("push1", 11, 28, -478, -1029);
    push_read("push2", 17, 24, -1680, -140);
    push_read("push3", -40, -18, 618, 140);

    // Read one edge after a push still sees the pre-push delay line.
    step(1'b1, OpPush, 35, 15, 0);
    read_check("early_read", 618, 140);
    read_check("push4", -1923, -2275);
    push_read("push5", -14, 23, 3804, 97);

    repeat (3) idle();
    check_eq("hold", int'(io_rd_real), int'(io_rd_imag), 3804, 97);

    step(1'b0, OpPush, 100, 100, 0);
    idle();
    read_check("novalid_push", 3804, 97);

    step(1'b1, OpBad, 100, 100, 0);
    idle();
    read_check("bad_opcode", 3804, 97);

    step(1'b1, OpCoef, 999, 999, 5);
    step(1'b1, OpCoef, -999, 999, 6);
    step(1'b1, OpCoef, 999, -999, 7);
    idle();
    read_check("coef_oob", 3804, 97);

    reset_dut();
    check_eq("mid_reset", int'(io_rd_real), int'(io_rd_imag), 0, 0);
    read_check("rst_read2", 0, 0);

    // Coefficient written at edge E is not seen by a read at E+1, but is by E+2 or later.
    step(1'b1, OpPush, 2, 1, 0);
    step(1'b1, OpCoef, 3, 4, 0);
    read_check("coef_early", 0, 0);
    read_check("coef_late", 2, 11);

    // (300+200j)^2 = 50000+120000j, wrapped to 16 bits.
    reset_dut();
    step(1'b1, OpCoef, 300, 200, 0);
    push_read("wrap", 300, 200, -15536, -11072);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
